// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM: state
// encoding, opcode constants, ALUOp / ALUSrcB / PCSource encodings, the
// packed control-word type and the DECODE dispatch helpers.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_IMM_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RT     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    function automatic logic opcode_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    // State entered after DECODE; unsupported opcodes fall back to FETCH.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEM_ADDR;
            OP_RTYPE:     return S_EXECUTE;
            OP_BEQ:       return S_BRANCH;
            OP_J:         return S_JUMP;
            OP_ADDI:      return S_EXEC_I;
            default:      return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode              IR[31:26], sampled only in DECODE
//   mem_ready           memory finishes the current access this cycle
//   PCWrite..RegDst     Moore datapath controls (FETCH IRWrite/PCWrite also
//                       qualified by mem_ready); ALUOP1/ALUOP0 go to alu_control
//   state               current state encoding (debug)
//   illegal_op          sticky flag, set when an unsupported opcode is decoded
//   instr_count         retired-instruction counter, wraps modulo 2^CNT_W
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic [1:0]       PCSource,
    output logic             ALUOP1,
    output logic             ALUOP0,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic             store_q;       // instruction in flight is sw (vs lw)
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             decode_illegal;
    ctrl_t            ctrl;

    // Next-state logic and retire/illegal events.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d        = state_q;
        retire         = 1'b0;
        decode_illegal = 1'b0;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                state_d        = decode_next(opcode);
                decode_illegal = !opcode_legal(opcode);
            end
            S_MEM_ADDR:  state_d = store_q ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE:   state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_IMM_WB;
            S_MEM_WB, S_ALU_WB, S_IMM_WB, S_BRANCH, S_JUMP: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default:     state_d = S_FETCH;   // unreachable encodings recover
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            store_q   <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) store_q <= (opcode == OP_SW);
            if (decode_illegal)      illegal_q <= 1'b1;
            if (retire)              count_q <= count_q + CNT_W'(1);
        end
    end

    // Moore output decode.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUSRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_IMM_WB:    ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUSRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default:     ctrl = '0;
        endcase
        // NOTE: reset forces the controls low combinationally, so they drop
        // the instant rst_n falls even mid-instruction, and FETCH controls
        // reappear as soon as it rises, without waiting for a clock.
        if (!rst_n) ctrl = '0;
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign PCSource    = ctrl.pc_source;
    assign ALUOP1      = ctrl.alu_op[1];
    assign ALUOP0      = ctrl.alu_op[0];
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign state       = state_q;
    assign illegal_op  = illegal_q;
    assign instr_count = count_q;

endmodule
